// File: rtl/fifo_pkg.sv
// Shared sizing helpers, parameter sanity checks and operation encoding
// for the circular-pointer FIFO family.
package fifo_pkg;

   // Pointer width never collapses to zero bits, even for tiny depths.
   function automatic int clog2_min1(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic bit cfg_ok(input int depth, input int af_thresh, input int ae_thresh);
      return (depth >= 2) && (af_thresh >= 1) && (af_thresh <= depth) &&
             (ae_thresh >= 0) && (ae_thresh <= depth - 1);
   endfunction

   // Encoded as {push_ok, pop_ok} so the accept pair casts straight in.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } op_e;

endpackage

// File: rtl/circ_ptr_wrap.sv
// Pointer register that advances on inc and wraps from DEPTH-1 back to 0,
// so values >= DEPTH are never produced for non-power-of-two depths.
module circ_ptr_wrap
   import fifo_pkg::*;
#(
   parameter  int DEPTH = 5,
   localparam int PW    = clog2_min1(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [PW-1:0] ptr_q, ptr_d;

   always_comb begin
      // NOTE: default assignment first so every path drives ptr_d and no latch is inferred.
      ptr_d = ptr_q;
      if (inc) begin
         ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, avoiding order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/circ_ptr_fifo_gen.sv
// Circular-pointer FIFO for any DEPTH >= 2 with occupancy count, threshold
// flags, sticky overflow/underflow and FWFT or registered read.
module circ_ptr_fifo_gen
   import fifo_pkg::*;
#(
   parameter  int WIDTH     = 8,
   parameter  int DEPTH     = 5,
   parameter  int FWFT      = 1,
   parameter  int AF_THRESH = DEPTH - 1,
   parameter  int AE_THRESH = 1,
   localparam int PW        = clog2_min1(DEPTH),
   localparam int CW        = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] data_in,
   input  logic             pop,
   input  logic             clr_err,
   output logic [WIDTH-1:0] data_out,
   output logic             data_out_vld,
   output logic             empty,
   output logic             full,
   output logic             almost_empty,
   output logic             almost_full,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow
);

   if (!cfg_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_cfg_err
      $error("circ_ptr_fifo_gen: DEPTH must be >= 2 and thresholds within range");
   end

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             push_ok, pop_ok;
   op_e              op;
   logic [WIDTH-1:0] mem_q [0:DEPTH-1];

   assign empty        = (count_q == '0);
   assign full         = (count_q == DEPTH_C);
   assign almost_empty = (count_q <= AE_C);
   assign almost_full  = (count_q >= AF_C);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // Accept decisions look only at pre-edge state: a push at full is refused even alongside a pop.
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign op      = op_e'({push_ok, pop_ok});

   circ_ptr_wrap #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (push_ok),
      .ptr   (wr_ptr)
   );

   circ_ptr_wrap #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pop_ok),
      .ptr   (rd_ptr)
   );

   always_comb begin
      count_d = count_q;
      unique case (op)
         OP_PUSH: count_d = count_q + CW'(1);
         OP_POP:  count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // A same-cycle error event wins over the clear.
      overflow_d  = (overflow_q  & ~clr_err) | (push & full);
      underflow_d = (underflow_q & ~clr_err) | (pop & empty);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // NOTE: storage is deliberately not reset; the count/empty logic guarantees stale words are never presented as valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr] <= data_in;
      end
   end

   if (FWFT != 0) begin : g_fwft
      // Head word shows combinationally; forced to zero while empty so reset reads back 0.
      assign data_out     = empty ? '0 : mem_q[rd_ptr];
      assign data_out_vld = ~empty;
   end else begin : g_reg_read
      logic [WIDTH-1:0] dout_q;
      logic             vld_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
         end else begin
            vld_q <= pop_ok;
            if (pop_ok) begin
               dout_q <= mem_q[rd_ptr];
            end
         end
      end

      assign data_out     = dout_q;
      assign data_out_vld = vld_q;
   end

endmodule

// File: tb/tb_circ_ptr_fifo_gen.sv
// Directed bench for circ_ptr_fifo_gen: three configurations, scoreboard queues
// filled by the stimulus and drained by per-instance read monitors.
module tb_circ_ptr_fifo_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: DEPTH=5, FWFT
   logic       a_push = 0, a_pop = 0, a_clr = 0;
   logic [7:0] a_din = '0, a_dout;
   logic       a_vld, a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
   logic [2:0] a_count;
   // Instance B: DEPTH=3, FWFT
   logic       b_push = 0, b_pop = 0, b_clr = 0;
   logic [7:0] b_din = '0, b_dout;
   logic       b_vld, b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
   logic [2:0] b_count;
   // Instance C: DEPTH=7, registered read
   logic       c_push = 0, c_pop = 0, c_clr = 0;
   logic [7:0] c_din = '0, c_dout;
   logic       c_vld, c_empty, c_full, c_ae, c_af, c_ovf, c_unf;
   logic [2:0] c_count;

   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   logic [7:0] q_c[$];

   circ_ptr_fifo_gen #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u_a (
      .clk(clk), .rst_n(rst_n), .push(a_push), .data_in(a_din), .pop(a_pop), .clr_err(a_clr),
      .data_out(a_dout), .data_out_vld(a_vld), .empty(a_empty), .full(a_full),
      .almost_empty(a_ae), .almost_full(a_af), .count(a_count),
      .overflow(a_ovf), .underflow(a_unf)
   );

   circ_ptr_fifo_gen #(.WIDTH(8), .DEPTH(3), .FWFT(1)) u_b (
      .clk(clk), .rst_n(rst_n), .push(b_push), .data_in(b_din), .pop(b_pop), .clr_err(b_clr),
      .data_out(b_dout), .data_out_vld(b_vld), .empty(b_empty), .full(b_full),
      .almost_empty(b_ae), .almost_full(b_af), .count(b_count),
      .overflow(b_ovf), .underflow(b_unf)
   );

   circ_ptr_fifo_gen #(.WIDTH(8), .DEPTH(7), .FWFT(0)) u_c (
      .clk(clk), .rst_n(rst_n), .push(c_push), .data_in(c_din), .pop(c_pop), .clr_err(c_clr),
      .data_out(c_dout), .data_out_vld(c_vld), .empty(c_empty), .full(c_full),
      .almost_empty(c_ae), .almost_full(c_af), .count(c_count),
      .overflow(c_ovf), .underflow(c_unf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // FWFT monitors: a read completes when pop is asserted while valid data is presented.
   always @(negedge clk) begin
      if (rst_n && a_pop && a_vld) begin
         if (q_a.size() == 0) check("a_unexpected_read", {24'h0, a_dout}, 32'hFFFF_FFFF);
         else                 check("a_rd_data", {24'h0, a_dout}, {24'h0, q_a.pop_front()});
      end
      if (rst_n && b_pop && b_vld) begin
         if (q_b.size() == 0) check("b_unexpected_read", {24'h0, b_dout}, 32'hFFFF_FFFF);
         else                 check("b_rd_data", {24'h0, b_dout}, {24'h0, q_b.pop_front()});
      end
      // Registered-read monitor: valid is the completion strobe.
      if (rst_n && c_vld) begin
         if (q_c.size() == 0) check("c_unexpected_read", {24'h0, c_dout}, 32'hFFFF_FFFF);
         else                 check("c_rd_data", {24'h0, c_dout}, {24'h0, q_c.pop_front()});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_a_count", a_count, 0);
      check("rst_a_empty", a_empty, 1);
      check("rst_a_full", a_full, 0);
      check("rst_a_ae", a_ae, 1);
      check("rst_a_af", a_af, 0);
      check("rst_a_ovf_unf", {a_ovf, a_unf}, 0);
      check("rst_a_vld", a_vld, 0);
      check("rst_a_dout", a_dout, 0);
      check("rst_c_vld", c_vld, 0);
      check("rst_c_dout", c_dout, 0);
      rst_n = 1'b1;

      // T1: fill DEPTH=5, overflow on a 6th push, drain in order
      for (int i = 0; i < 5; i++) begin
         a_push = 1'b1;
         a_din  = 8'(8'h11 + i);
         q_a.push_back(8'(8'h11 + i));
         step();
         check("t1_count", a_count, i + 1);
         check("t1_af", a_af, (i + 1) >= 4);
         check("t1_ae", a_ae, (i + 1) <= 1);
      end
      check("t1_full", a_full, 1);
      a_din = 8'h16;
      step();
      a_push = 1'b0;
      check("t1_overflow", a_ovf, 1);
      check("t1_count_after_ovf", a_count, 5);
      a_pop = 1'b1;
      repeat (5) step();
      a_pop = 1'b0;
      check("t1_empty", a_empty, 1);
      check("t1_count_drained", a_count, 0);
      a_clr = 1'b1;
      step();
      a_clr = 1'b0;
      check("t1_ovf_cleared", a_ovf, 0);

      // T2: 12 words through a one-deep steady state; wr_ptr wraps 4->0 twice
      for (int k = 0; k < 12; k++) begin
         a_push = 1'b1;
         a_din  = 8'(k);
         a_pop  = (k > 0);
         q_a.push_back(8'(k));
         step();
         check("t2_wr_ptr", 32'(u_a.u_wr_ptr.ptr), (k + 1) % 5);
         check("t2_count", a_count, 1);
      end
      a_push = 1'b0;
      a_pop  = 1'b1;
      step();
      a_pop  = 1'b0;
      check("t2_empty", a_empty, 1);

      // T4: underflow, clear, and error beating a same-cycle clear
      a_pop = 1'b1;
      check("t4_vld_before", a_vld, 0);
      step();
      a_pop = 1'b0;
      check("t4_underflow", a_unf, 1);
      check("t4_vld_after", a_vld, 0);
      check("t4_count", a_count, 0);
      a_clr = 1'b1;
      step();
      a_clr = 1'b0;
      check("t4_unf_cleared", a_unf, 0);
      a_pop = 1'b1;
      a_clr = 1'b1;
      step();
      a_pop = 1'b0;
      a_clr = 1'b0;
      check("t4_err_wins_clear", a_unf, 1);

      // T3: DEPTH=3 full with push+pop, then push+pop at count 1
      for (int i = 0; i < 3; i++) begin
         b_push = 1'b1;
         b_din  = 8'(8'h31 + i);
         q_b.push_back(8'(8'h31 + i));
         step();
      end
      check("t3_full", b_full, 1);
      b_din = 8'h34;
      b_pop = 1'b1;
      step();
      b_push = 1'b0;
      check("t3_overflow", b_ovf, 1);
      check("t3_count2", b_count, 2);
      step();
      check("t3_count1", b_count, 1);
      b_push = 1'b1;
      b_din  = 8'hAA;
      q_b.push_back(8'hAA);
      step();
      b_push = 1'b0;
      check("t3_count_hold", b_count, 1);
      step();
      b_pop = 1'b0;
      check("t3_empty", b_empty, 1);

      // T5: registered read, one-cycle latency, valid pulses once
      c_push = 1'b1;
      c_din  = 8'h5A;
      q_c.push_back(8'h5A);
      step();
      c_push = 1'b0;
      c_pop  = 1'b1;
      check("t5_vld_not_early", c_vld, 0);
      step();
      c_pop = 1'b0;
      check("t5_vld", c_vld, 1);
      check("t5_dout", c_dout, 8'h5A);
      step();
      check("t5_vld_drop", c_vld, 0);
      check("t5_dout_hold", c_dout, 8'h5A);
      for (int i = 1; i <= 3; i++) begin
         c_push = 1'b1;
         c_din  = 8'(i);
         q_c.push_back(8'(i));
         step();
      end
      c_push = 1'b0;
      c_pop  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t5_burst_vld", c_vld, 1);
      end
      c_pop = 1'b0;
      step();
      check("t5_burst_end_vld", c_vld, 0);
      check("t5_empty", c_empty, 1);

      // T6: asynchronous reset mid-burst at count 3 clears everything immediately
      for (int i = 0; i < 3; i++) begin
         a_push = 1'b1;
         a_din  = 8'(8'h21 + i);
         q_a.push_back(8'(8'h21 + i));
         step();
      end
      check("t6_count3", a_count, 3);
      a_din = 8'h24;
      #3;
      rst_n  = 1'b0;
      a_push = 1'b0;
      #1;
      q_a.delete();
      check("t6_count", a_count, 0);
      check("t6_empty", a_empty, 1);
      check("t6_ae_af", {a_ae, a_af}, 2'b10);
      check("t6_errs", {a_ovf, a_unf}, 0);
      check("t6_vld", a_vld, 0);
      step();
      rst_n = 1'b1;
      step();
      check("t6_count_after", a_count, 0);

      check("sb_a_drained", q_a.size(), 0);
      check("sb_b_drained", q_b.size(), 0);
      check("sb_c_drained", q_c.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
